// File: rtl/lspl_wb_buffer_pkg.sv
// Shared types for the load/store writeback buffer: the entry lifecycle
// states, the per-entry storage record and its cleared value.
package lspl_wb_buffer_pkg;

  // Storage width of the wdata field; must be at least the DataW of any instance.
  localparam int unsigned LSPL_WB_DATAW = 65;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ALLOC  = 2'd1,
    FILLED = 2'd2
  } lspl_wb_state_e;

  typedef struct packed {
    lspl_wb_state_e           state;
    logic [4:0]               rd;
    logic                     we;
    logic                     err;
    logic                     is_cap;
    logic                     wrsv;
    logic [LSPL_WB_DATAW-1:0] wdata;
  } lspl_wb_entry_t;

  localparam lspl_wb_entry_t NULL_LSPL_WB_ENTRY = '{
    state:  FREE,
    rd:     5'd0,
    we:     1'b0,
    err:    1'b0,
    is_cap: 1'b0,
    wrsv:   1'b0,
    wdata:  '0
  };

endpackage

// File: rtl/lspl_waw_match.sv
// WAW reservation matcher: flags every live entry whose destination register
// is overwritten by a younger issued instruction (rd0/rd1, x0 ignored).
module lspl_waw_match #(
  parameter int unsigned Depth = 8
) (
  input  logic [Depth-1:0][4:0] rd_i,
  input  logic [Depth-1:0]      live_i,
  input  logic                  waw_valid_i,
  input  logic [4:0]            rd0_i,
  input  logic [4:0]            rd1_i,
  output logic [Depth-1:0]      clr_o
);

  // Per-entry compare against both younger destinations.
  always_comb begin
    clr_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      clr_o[i] = waw_valid_i & live_i[i] &
                 (((rd_i[i] == rd0_i) & (rd0_i != 5'd0)) |
                  ((rd_i[i] == rd1_i) & (rd1_i != 5'd0)));
    end
  end

endmodule

// File: rtl/lspl_wb_buffer.sv
// In-order load/store writeback buffer: entries are allocated at issue,
// filled by the LSU response and retired in order to commit. Tracks the WAW
// write reservation per entry and latches response errors until flush.
// Optional macro LSPL_WB_BYPASS_EN: zero-latency bypass of a response that
// fills the head entry straight to the commit port.
module lspl_wb_buffer
  import lspl_wb_buffer_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned DataW = 65,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             debug_mode_i,
  input  logic             alloc_valid_i,
  input  logic [4:0]       alloc_rd_i,
  output logic             alloc_rdy_o,
  input  logic             resp_valid_i,
  output logic             resp_rdy_o,
  input  logic             resp_we_i,
  input  logic             resp_err_i,
  input  logic             resp_is_cap_i,
  input  logic [DataW-1:0] resp_wdata_i,
  input  logic             waw_valid_i,
  input  logic [4:0]       waw_rd0_i,
  input  logic [4:0]       waw_rd1_i,
  output logic             out_valid_o,
  input  logic             out_rdy_i,
  output logic             out_we_o,
  output logic             out_err_o,
  output logic             out_is_cap_o,
  output logic [4:0]       out_waddr_o,
  output logic [DataW-1:0] out_wdata_o,
  output logic             out_wrsv_o,
  output logic [CntW-1:0]  count_o,
  output logic             err_active_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  lspl_wb_entry_t entries_q [Depth];
  logic [PtrW-1:0] alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic [Depth-1:0][4:0] rd_vec;
  logic [Depth-1:0]      live_vec;
  logic [Depth-1:0]      waw_clr;
  lspl_wb_entry_t        head_e;
  logic                  alloc_fire, resp_fire, out_fire, bypass;

  // Gather per-entry rd and liveness for the WAW matcher.
  always_comb begin
    rd_vec   = '0;
    live_vec = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      rd_vec[i]   = entries_q[i].rd;
      live_vec[i] = (entries_q[i].state == ALLOC) | (entries_q[i].state == FILLED);
    end
  end

  lspl_waw_match #(
    .Depth(Depth)
  ) u_waw_match (
    .rd_i       (rd_vec),
    .live_i     (live_vec),
    .waw_valid_i(waw_valid_i),
    .rd0_i      (waw_rd0_i),
    .rd1_i      (waw_rd1_i),
    .clr_o      (waw_clr)
  );

  assign head_e      = entries_q[head_ptr_q];
  assign alloc_rdy_o = count_q < CntW'(Depth);
  assign resp_rdy_o  = (entries_q[fill_ptr_q].state == ALLOC) & ~err_q;
  assign alloc_fire  = alloc_valid_i & alloc_rdy_o;
  assign resp_fire   = resp_valid_i & resp_rdy_o;
  assign out_fire    = out_valid_o & out_rdy_i;

`ifdef LSPL_WB_BYPASS_EN
  assign bypass = resp_fire & (head_ptr_q == fill_ptr_q);
`else
  assign bypass = 1'b0;
`endif

  // Commit port: head storage, or the live response when it is bypassed.
  always_comb begin
    out_valid_o  = (head_e.state == FILLED) | bypass;
    out_we_o     = head_e.we;
    out_err_o    = head_e.err;
    out_is_cap_o = head_e.is_cap;
    out_waddr_o  = head_e.rd;
    out_wdata_o  = head_e.wdata[DataW-1:0];
    out_wrsv_o   = head_e.wrsv & head_e.we;
    if (bypass) begin
      out_we_o     = resp_we_i;
      out_err_o    = resp_err_i;
      out_is_cap_o = resp_is_cap_i;
      out_wdata_o  = resp_wdata_i;
      out_wrsv_o   = head_e.wrsv & ~waw_clr[head_ptr_q] & resp_we_i;
    end
  end

  assign count_o      = count_q;
  assign err_active_o = ~debug_mode_i & (err_q | (resp_valid_i & resp_err_i));

  // Entry lifecycle, pointers, occupancy and error latch; flush wins over all.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) entries_q[i] <= NULL_LSPL_WB_ENTRY;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) entries_q[i] <= NULL_LSPL_WB_ENTRY;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (waw_clr[i]) entries_q[i].wrsv <= 1'b0;
      end
      if (alloc_fire) begin
        entries_q[alloc_ptr_q].state  <= ALLOC;
        entries_q[alloc_ptr_q].rd     <= alloc_rd_i;
        entries_q[alloc_ptr_q].wrsv   <= (alloc_rd_i != 5'd0);
        entries_q[alloc_ptr_q].we     <= 1'b0;
        entries_q[alloc_ptr_q].err    <= 1'b0;
        entries_q[alloc_ptr_q].is_cap <= 1'b0;
        alloc_ptr_q <= alloc_ptr_q + 1'b1;
      end
      if (resp_fire) begin
        entries_q[fill_ptr_q].state  <= FILLED;
        entries_q[fill_ptr_q].we     <= resp_we_i;
        entries_q[fill_ptr_q].err    <= resp_err_i;
        entries_q[fill_ptr_q].is_cap <= resp_is_cap_i;
        entries_q[fill_ptr_q].wdata  <= LSPL_WB_DATAW'(resp_wdata_i);
        fill_ptr_q <= fill_ptr_q + 1'b1;
        if (resp_err_i && !debug_mode_i) err_q <= 1'b1;
      end
      // Placed after the fill so a bypassed retire frees the entry directly.
      if (out_fire) begin
        entries_q[head_ptr_q].state <= FREE;
        head_ptr_q <= head_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(alloc_fire) - CntW'(out_fire);
    end
  end

  // A response must always target an allocated, unfilled entry.
  a_resp_has_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (resp_valid_i && !flush_i) |-> (entries_q[fill_ptr_q].state == ALLOC));

endmodule

// File: tb/tb_lspl_wb_buffer.sv
// Scoreboard bench for lspl_wb_buffer: stimulus pushes expected commit
// records; a negedge monitor pops and compares on each retire handshake.
module tb_lspl_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0, debug_mode_i = 1'b0;
  logic        alloc_valid_i = 1'b0;
  logic [4:0]  alloc_rd_i = '0;
  logic        alloc_rdy_o;
  logic        resp_valid_i = 1'b0, resp_rdy_o;
  logic        resp_we_i = 1'b0, resp_err_i = 1'b0, resp_is_cap_i = 1'b0;
  logic [64:0] resp_wdata_i = '0;
  logic        waw_valid_i = 1'b0;
  logic [4:0]  waw_rd0_i = '0, waw_rd1_i = '0;
  logic        out_valid_o, out_rdy_i = 1'b0;
  logic        out_we_o, out_err_o, out_is_cap_o, out_wrsv_o;
  logic [4:0]  out_waddr_o;
  logic [64:0] out_wdata_o;
  logic [3:0]  count_o;
  logic        err_active_o;

  typedef struct packed {
    logic [4:0]  waddr;
    logic        we;
    logic        err;
    logic        cap;
    logic        wrsv;
    logic [64:0] wdata;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] rdq[$];
  int total = 0;
  int bad   = 0;

  lspl_wb_buffer #(
    .Depth(8),
    .DataW(65)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .alloc_valid_i(alloc_valid_i),
    .alloc_rd_i   (alloc_rd_i),
    .alloc_rdy_o  (alloc_rdy_o),
    .resp_valid_i (resp_valid_i),
    .resp_rdy_o   (resp_rdy_o),
    .resp_we_i    (resp_we_i),
    .resp_err_i   (resp_err_i),
    .resp_is_cap_i(resp_is_cap_i),
    .resp_wdata_i (resp_wdata_i),
    .waw_valid_i  (waw_valid_i),
    .waw_rd0_i    (waw_rd0_i),
    .waw_rd1_i    (waw_rd1_i),
    .out_valid_o  (out_valid_o),
    .out_rdy_i    (out_rdy_i),
    .out_we_o     (out_we_o),
    .out_err_o    (out_err_o),
    .out_is_cap_o (out_is_cap_o),
    .out_waddr_o  (out_waddr_o),
    .out_wdata_o  (out_wdata_o),
    .out_wrsv_o   (out_wrsv_o),
    .count_o      (count_o),
    .err_active_o (err_active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic alloc1(input logic [4:0] rd);
    alloc_valid_i = 1'b1;
    alloc_rd_i    = rd;
    tick();
    alloc_valid_i = 1'b0;
    rdq.push_back(rd);
  endtask

  task automatic drive_resp(input logic we, input logic err, input logic cap,
                            input logic [64:0] data);
    resp_valid_i  = 1'b1;
    resp_we_i     = we;
    resp_err_i    = err;
    resp_is_cap_i = cap;
    resp_wdata_i  = data;
  endtask

  task automatic clear_resp();
    resp_valid_i  = 1'b0;
    resp_we_i     = 1'b0;
    resp_err_i    = 1'b0;
    resp_is_cap_i = 1'b0;
  endtask

  task automatic resp1(input logic we, input logic err, input logic cap,
                       input logic [64:0] data, input logic wrsv);
    logic [4:0] r;
    r = rdq.pop_front();
    sb.push_back('{waddr: r, we: we, err: err, cap: cap, wrsv: wrsv, wdata: data});
    drive_resp(we, err, cap, data);
    tick();
    clear_resp();
  endtask

  task automatic flush1();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sb.delete();
    rdq.delete();
  endtask

  // Monitor: every commit handshake retires the oldest expected record.
  always @(negedge clk_i) begin
    if (rst_ni && !flush_i && out_valid_o && out_rdy_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL retire: unexpected commit rd=%0d data=%0h", out_waddr_o, out_wdata_o);
      end else begin
        exp_t e, a;
        e = sb.pop_front();
        a = '{waddr: out_waddr_o, we: out_we_o, err: out_err_o, cap: out_is_cap_o,
              wrsv: out_wrsv_o, wdata: out_wdata_o};
        if (a !== e) begin
          bad++;
          $display("FAIL retire: got rd=%0d we=%0b err=%0b cap=%0b wrsv=%0b data=%0h expected rd=%0d we=%0b err=%0b cap=%0b wrsv=%0b data=%0h",
                   a.waddr, a.we, a.err, a.cap, a.wrsv, a.wdata,
                   e.waddr, e.we, e.err, e.cap, e.wrsv, e.wdata);
        end
      end
    end
  end

  initial begin
    logic [64:0] d;

    // Reset state
    tick(); tick();
    chk("rst_count", 32'(count_o), 0);
    chk("rst_alloc_rdy", 32'(alloc_rdy_o), 1);
    chk("rst_resp_rdy", 32'(resp_rdy_o), 0);
    chk("rst_out_valid", 32'(out_valid_o), 0);
    chk("rst_err_active", 32'(err_active_o), 0);
    chk("rst_out_fields", 32'({out_we_o, out_wrsv_o, out_waddr_o}), 0);
    rst_ni = 1'b1;
    tick();

    // Basic alloc / resp / retire
    alloc1(5'd5);
    chk("t1_count_alloc", 32'(count_o), 1);
    chk("t1_resp_rdy", 32'(resp_rdy_o), 1);
    chk("t1_out_valid_pre", 32'(out_valid_o), 0);
    resp1(1'b1, 1'b0, 1'b0, 65'h1234, 1'b1);
    chk("t1_out_valid_next", 32'(out_valid_o), 1);
    chk("t1_count_filled", 32'(count_o), 1);
    out_rdy_i = 1'b1;
    tick();
    chk("t1_count_retired", 32'(count_o), 0);
    chk("t1_out_valid_after", 32'(out_valid_o), 0);

    // WAW clears the reservation before the response
    alloc1(5'd7);
    waw_valid_i = 1'b1; waw_rd0_i = 5'd7; waw_rd1_i = 5'd0;
    tick();
    waw_valid_i = 1'b0;
    resp1(1'b1, 1'b0, 1'b0, 65'hABCD, 1'b0);
    tick();

    // WAW via rd1 hits only the matching entry; we=0 masks wrsv
    alloc1(5'd9);
    alloc1(5'd10);
    waw_valid_i = 1'b1; waw_rd0_i = 5'd0; waw_rd1_i = 5'd9;
    tick();
    waw_valid_i = 1'b0;
    resp1(1'b1, 1'b0, 1'b1, {1'b1, 64'h1}, 1'b0);
    resp1(1'b0, 1'b0, 1'b0, 65'h5, 1'b0);
    tick(); tick();

    // Same-cycle WAW does not touch the entry being allocated
    waw_valid_i = 1'b1; waw_rd0_i = 5'd12; waw_rd1_i = 5'd12;
    alloc1(5'd12);
    waw_valid_i = 1'b0;
    resp1(1'b1, 1'b0, 1'b0, 65'h77, 1'b1);
    tick(); tick();
    chk("t2_count_empty", 32'(count_o), 0);

    // Fill to capacity, refused alloc under retire, wrap over 3 rounds
    for (int r = 0; r < 3; r++) begin
      out_rdy_i = 1'b0;
      for (int i = 0; i < 8; i++) alloc1(5'(r * 8 + i + 1));
      chk("t3_full_count", 32'(count_o), 8);
      chk("t3_full_alloc_rdy", 32'(alloc_rdy_o), 0);
      d = 65'(r * 256 + 100);
      resp1(1'b1, 1'b0, 1'b0, d, 1'b1);
      out_rdy_i = 1'b1; alloc_valid_i = 1'b1; alloc_rd_i = 5'd31;
      #1;
      chk("t3_full_retire_alloc_rdy", 32'(alloc_rdy_o), 0);
      tick();
      alloc_valid_i = 1'b0; out_rdy_i = 1'b0;
      chk("t3_after_retire_count", 32'(count_o), 7);
      chk("t3_after_retire_alloc_rdy", 32'(alloc_rdy_o), 1);
      alloc1(5'(r * 8 + 20));
      chk("t3_refill_count", 32'(count_o), 8);
      out_rdy_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
        d = 65'(r * 256 + i);
        resp1(1'b1, 1'b0, 1'(i), d, 1'b1);
      end
      tick(); tick();
      chk("t3_drained_count", 32'(count_o), 0);
    end

    // Error latch with debug off, then flush
    out_rdy_i = 1'b0; debug_mode_i = 1'b0;
    alloc1(5'd4);
    alloc1(5'd6);
    drive_resp(1'b0, 1'b1, 1'b0, 65'h0);
    #1;
    chk("t4_err_active_now", 32'(err_active_o), 1);
    chk("t4_err_resp_accepted", 32'(resp_rdy_o), 1);
    tick();
    clear_resp();
    chk("t4_err_latched", 32'(err_active_o), 1);
    chk("t4_resp_blocked", 32'(resp_rdy_o), 0);
    flush1();
    chk("t4_flush_count", 32'(count_o), 0);
    chk("t4_flush_err", 32'(err_active_o), 0);
    chk("t4_flush_out_valid", 32'(out_valid_o), 0);

    // Error with debug on: no latch
    debug_mode_i = 1'b1;
    alloc1(5'd4);
    alloc1(5'd6);
    drive_resp(1'b0, 1'b1, 1'b0, 65'h0);
    #1;
    chk("t4d_err_active_now", 32'(err_active_o), 0);
    tick();
    clear_resp();
    chk("t4d_resp_rdy", 32'(resp_rdy_o), 1);
    chk("t4d_err_active", 32'(err_active_o), 0);
    flush1();
    debug_mode_i = 1'b0;

    // Flush coinciding with alloc and retire discards both
    alloc1(5'd1);
    alloc1(5'd2);
    alloc1(5'd3);
    resp1(1'b1, 1'b0, 1'b0, 65'h11, 1'b1);
    resp1(1'b1, 1'b0, 1'b0, 65'h22, 1'b1);
    resp1(1'b1, 1'b0, 1'b0, 65'h33, 1'b1);
    chk("t5_filled_count", 32'(count_o), 3);
    flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_rd_i = 5'd8; out_rdy_i = 1'b1;
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0;
    sb.delete();
    rdq.delete();
    chk("t5_out_valid", 32'(out_valid_o), 0);
    chk("t5_count", 32'(count_o), 0);
    tick();
    chk("t5_count_stays", 32'(count_o), 0);
    out_rdy_i = 1'b0;

`ifdef LSPL_WB_BYPASS_EN
    // Zero-latency bypass on an empty path
    out_rdy_i = 1'b1;
    alloc1(5'd3);
    sb.push_back('{waddr: 5'd3, we: 1'b1, err: 1'b0, cap: 1'b1, wrsv: 1'b1, wdata: 65'h5A5A});
    void'(rdq.pop_front());
    drive_resp(1'b1, 1'b0, 1'b1, 65'h5A5A);
    #1;
    chk("t6_bypass_valid", 32'(out_valid_o), 1);
    tick();
    clear_resp();
    chk("t6_bypass_count", 32'(count_o), 0);
    chk("t6_bypass_valid_after", 32'(out_valid_o), 0);
    out_rdy_i = 1'b0;
`endif

    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
